ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller placed directly upstream of ram_4096; uses the 4096x64 RAM as FIFO storage.
- Accepts a valid/ready push stream, generates ram_4096 write/read strobes and addresses, and prefetches RAM read data into a 2-entry output buffer.
- Presents a valid/ready pop stream to the consumer, plus level and almost-full status.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_fifo_ctrl_if.sv | 24 ++
 rtl/ram_fifo_obuf.sv | 51 +++++
 rtl/ram_fifo_ctrl.sv | 90 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared RAM geometry for ram_fifo_ctrl and its ram_4096 storage.
//   RAM_WIDTH : data word width
//   ADDR_SIZE : RAM address width (depth = 2**ADDR_SIZE)
//   DEPTH     : RAM depth in words
//   PTR_W     : FIFO pointer width (one extra wrap bit)
package ram_pkg;
    localparam int unsigned RAM_WIDTH = 64;
    localparam int unsigned ADDR_SIZE = 12;
    localparam int unsigned DEPTH     = 1 << ADDR_SIZE;
    localparam int unsigned PTR_W     = ADDR_SIZE + 1;
    localparam int unsigned AF_THRESH = 4032;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream bundle of ram_fifo_ctrl.
//   wr_valid/wr_ready/wr_data : producer -> FIFO push stream
//   rd_valid/rd_ready/rd_data : FIFO -> consumer pop stream
// slave modport is the FIFO side, master the producer/consumer side.
interface ram_fifo_ctrl_if #(
    parameter int unsigned WIDTH = ram_pkg::RAM_WIDTH
) ();
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer holding prefetched RAM words.
//   clk, rst_n    : clock, async active-low reset
//   clear         : synchronous drop of all entries
//   capture       : write capture_data into the buffer this edge
//   rd_valid/rd_ready/rd_data : pop stream (rd_data = head)
//   count         : entries held, used as prefetch credit
module ram_fifo_obuf #(
    parameter int unsigned WIDTH = ram_pkg::RAM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             capture,
    input  logic [WIDTH-1:0] capture_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       cnt;
    logic             pop;

    assign rd_valid = (cnt != 2'd0);
    assign rd_data  = head;
    assign count    = cnt;
    assign pop      = rd_valid && rd_ready && !clear;

    // head is only overwritten when a newer word moves in, so it keeps
    // the last popped value while the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            if (pop && cnt == 2'd2)
                head <= tail;
            if (capture) begin
                if (cnt == 2'd0 || (cnt == 2'd1 && pop))
                    head <= capture_data;
                else
                    tail <= capture_data;
            end
            cnt <= cnt + 2'(capture) - 2'(pop);
        end
    end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller using ram_4096 (1-cycle read latency) as storage,
// with a 2-entry prefetch buffer in front of the consumer.
//   clk, rst_n  : clock, async active-low reset
//   flush       : synchronous clear of all contents
//   fifo        : push/pop streams (slave side)
//   level       : words held in RAM + in flight + buffer
//   almost_full : level >= AF_THRESH
//   ram_*       : ram_4096 write/read strobes, addresses and data
module ram_fifo_ctrl #(
    parameter int unsigned RAM_WIDTH = ram_pkg::RAM_WIDTH,
    parameter int unsigned ADDR_SIZE = ram_pkg::ADDR_SIZE,
    parameter int unsigned AF_THRESH = ram_pkg::AF_THRESH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    ram_fifo_ctrl_if.slave       fifo,
    output logic [ADDR_SIZE:0]   level,
    output logic                 almost_full,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    output logic [ADDR_SIZE-1:0] ram_wr_address,
    output logic [ADDR_SIZE-1:0] ram_rd_address,
    output logic                 ram_write,
    output logic                 ram_read,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);
    localparam int unsigned DEPTH = 1 << ADDR_SIZE;

    logic [ADDR_SIZE:0] wr_ptr;
    logic [ADDR_SIZE:0] rd_ptr;
    logic [ADDR_SIZE:0] ram_cnt;
    logic               inflight;
    logic [1:0]         buf_cnt;
    logic               wr_ready;
    logic               push;
    logic               pop;

    assign ram_cnt  = wr_ptr - rd_ptr;
    assign wr_ready = (ram_cnt != (ADDR_SIZE+1)'(DEPTH)) && !flush;
    assign push     = fifo.wr_valid && wr_ready;
    assign pop      = fifo.rd_valid && fifo.rd_ready && !flush;

    assign fifo.wr_ready  = wr_ready;
    assign ram_write      = push;
    assign ram_wr_address = wr_ptr[ADDR_SIZE-1:0];
    assign ram_data_in    = fifo.wr_data;

    // Credit counts both buffered words and the one still in the RAM
    // pipeline, so the buffer can never overflow.
    assign ram_read = (ram_cnt != '0) &&
                      (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd2) &&
                      !flush;
    assign ram_rd_address = rd_ptr[ADDR_SIZE-1:0];

    assign almost_full = (level >= (ADDR_SIZE+1)'(AF_THRESH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            level    <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            level    <= '0;
        end else begin
            wr_ptr   <= wr_ptr + (ADDR_SIZE+1)'(push);
            rd_ptr   <= rd_ptr + (ADDR_SIZE+1)'(ram_read);
            inflight <= ram_read;
            level    <= level + (ADDR_SIZE+1)'(push) - (ADDR_SIZE+1)'(pop);
        end
    end

    // flush drives the buffer's clear, which also discards an in-flight return.
    ram_fifo_obuf #(
        .WIDTH(RAM_WIDTH)
    ) u_obuf (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (flush),
        .capture      (inflight),
        .capture_data (ram_data_out),
        .rd_ready     (fifo.rd_ready),
        .rd_valid     (fifo.rd_valid),
        .rd_data      (fifo.rd_data),
        .count        (buf_cnt)
    );
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
    localparam int unsigned W     = 64;
    localparam int unsigned AS    = 12;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned AF    = 4032;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.WIDTH(W)) fifo ();

    logic [AS:0]   level;
    logic          almost_full;
    logic [W-1:0]  ram_data_in;
    logic [W-1:0]  ram_data_out;
    logic [AS-1:0] ram_wr_address;
    logic [AS-1:0] ram_rd_address;
    logic          ram_write;
    logic          ram_read;

    ram_fifo_ctrl #(
        .RAM_WIDTH (W),
        .ADDR_SIZE (AS),
        .AF_THRESH (AF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .fifo           (fifo),
        .level          (level),
        .almost_full    (almost_full),
        .ram_data_in    (ram_data_in),
        .ram_wr_address (ram_wr_address),
        .ram_rd_address (ram_rd_address),
        .ram_write      (ram_write),
        .ram_read       (ram_read),
        .ram_data_out   (ram_data_out)
    );

    // Behavioural ram_4096: write at the edge, read data registered.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write) mem[ram_wr_address] <= ram_data_in;
        if (ram_read)  ram_data_out <= mem[ram_rd_address];
    end

    // Reference model: queue of all held words plus transaction counters.
    logic [W-1:0] q[$];
    int           mwr, mrd, outstanding;
    bit           prev_read;
    logic [W-1:0] last_head;
    bit           m_wr, m_rv, m_rr;
    int           vec, errs;

    typedef struct {
        bit           fl;
        bit           wv;
        logic [W-1:0] wd;
        bit           rr;
        bit           e_rv;
        logic [W-1:0] e_rd;
        int           e_lvl;
        bit           e_wrdy;
        bit           e_rread;
        bit           e_rwrite;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mwr = 0; mrd = 0; outstanding = 0;
        prev_read = 1'b0;
        last_head = '0;
    endtask

    task automatic check_model();
        int ramcnt;
        ramcnt = mwr - mrd;
        m_wr = (ramcnt != int'(DEPTH)) && !flush;
        m_rv = (outstanding - int'(prev_read)) > 0;
        m_rr = (ramcnt != 0) && (outstanding < 2) && !flush;
        chk("wr_ready", W'(fifo.wr_ready), W'(m_wr));
        chk("ram_write", W'(ram_write), W'(fifo.wr_valid && m_wr));
        if (fifo.wr_valid && m_wr) begin
            chk("ram_wr_address", W'(ram_wr_address), W'(mwr % int'(DEPTH)));
            chk("ram_data_in", ram_data_in, fifo.wr_data);
        end
        chk("rd_valid", W'(fifo.rd_valid), W'(m_rv));
        if (m_rv && q.size() > 0) chk("rd_data", fifo.rd_data, q[0]);
        else if (!m_rv)           chk("rd_data_hold", fifo.rd_data, last_head);
        chk("level", W'(level), W'(q.size()));
        chk("almost_full", W'(almost_full), W'(q.size() >= int'(AF)));
        chk("ram_read", W'(ram_read), W'(m_rr));
        if (m_rr) chk("ram_rd_address", W'(ram_rd_address), W'(mrd % int'(DEPTH)));
    endtask

    task automatic advance();
        if (m_rv && q.size() > 0) last_head = q[0];
        if (flush) begin
            q.delete();
            mwr = 0; mrd = 0; outstanding = 0;
            prev_read = 1'b0;
        end else begin
            if (fifo.rd_ready && m_rv) begin
                void'(q.pop_front());
                outstanding--;
            end
            if (fifo.wr_valid && m_wr) begin
                q.push_back(fifo.wr_data);
                mwr++;
            end
            if (m_rr) begin
                mrd++;
                outstanding++;
            end
            prev_read = m_rr;
        end
    endtask

    task automatic drive(input bit fl, input bit wv, input logic [W-1:0] wd, input bit rr);
        @(negedge clk);
        flush         = fl;
        fifo.wr_valid = wv;
        fifo.wr_data  = wd;
        fifo.rd_ready = rr;
    endtask

    task automatic step(input bit fl, input bit wv, input logic [W-1:0] wd, input bit rr);
        drive(fl, wv, wd, rr);
        #1;
        check_model();
        advance();
    endtask

    task automatic drain();
        for (int c = 0; c < 20000 && q.size() > 0; c++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("drain_level", W'(level), '0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wr_ready"}, W'(fifo.wr_ready), W'(1));
        chk({tag, "_rd_valid"}, W'(fifo.rd_valid), '0);
        chk({tag, "_level"}, W'(level), '0);
        chk({tag, "_ram_read"}, W'(ram_read), '0);
        chk({tag, "_ram_write"}, W'(ram_write), '0);
        chk({tag, "_almost_full"}, W'(almost_full), '0);
        chk({tag, "_rd_data"}, fifo.rd_data, '0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit got;
        vec = 0; errs = 0;
        fifo.wr_valid = 1'b0;
        fifo.wr_data  = '0;
        fifo.rd_ready = 1'b0;
        model_reset();

        // fl wv wd rr | rv rd lvl wrdy rread rwrite
        tbl[0] = '{0, 1, 64'h1, 0, 0, 64'h0, 0, 1, 0, 1};
        tbl[1] = '{0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 1, 0};
        tbl[2] = '{0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0};
        tbl[3] = '{0, 0, 64'h0, 0, 1, 64'h1, 1, 1, 0, 0};
        tbl[4] = '{0, 0, 64'h0, 1, 1, 64'h1, 1, 1, 0, 0};
        tbl[5] = '{0, 0, 64'h0, 0, 0, 64'h1, 0, 1, 0, 0};
        tbl[6] = '{1, 1, 64'h2, 0, 0, 64'h1, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 64'h7, 0, 0, 64'h1, 0, 1, 0, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;

        // Directed single-word latency, pop, empty hold and flush blocking.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].fl, tbl[i].wv, tbl[i].wd, tbl[i].rr);
            #1;
            chk($sformatf("tbl%0d_rd_valid", i), W'(fifo.rd_valid), W'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_rd_data", i), fifo.rd_data, tbl[i].e_rd);
            chk($sformatf("tbl%0d_level", i), W'(level), W'(tbl[i].e_lvl));
            chk($sformatf("tbl%0d_wr_ready", i), W'(fifo.wr_ready), W'(tbl[i].e_wrdy));
            chk($sformatf("tbl%0d_ram_read", i), W'(ram_read), W'(tbl[i].e_rread));
            chk($sformatf("tbl%0d_ram_write", i), W'(ram_write), W'(tbl[i].e_rwrite));
            check_model();
            advance();
        end
        step(1'b1, 1'b0, '0, 1'b0);

        // Fill to full, hold a stalled word, then drain in order.
        acc = 0;
        for (int c = 0; c < 5000; c++) begin
            step(1'b0, 1'b1, W'(acc), 1'b0);
            if (m_wr) acc++;
            else break;
        end
        chk("full_count", W'(acc), W'(DEPTH + 2));
        chk("full_level", W'(level), W'(DEPTH + 2));
        chk("full_almost_full", W'(almost_full), W'(1));
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 64'hDEAD, 1'b0);
        drain();
        chk("full_last_word", fifo.rd_data, W'(DEPTH + 1));

        // Streaming across pointer wrap.
        acc = 0;
        for (int c = 0; c < 40000 && acc < 10000; c++) begin
            step(1'b0, 1'b1, {$urandom(), $urandom()}, 1'b1);
            if (m_wr) acc++;
        end
        chk("stream_count", W'(acc), W'(10000));
        drain();

        // Consumer back-pressure 1-on/2-off.
        for (int c = 0; c < 1800; c++)
            step(1'b0, 1'b1, {$urandom(), $urandom()}, (c % 3) == 0);
        drain();

        // Flush with stored words and a read in flight.
        for (int c = 0; c < 100; c++) step(1'b0, 1'b1, W'(c + 1000), 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("flush_read_issued", W'(ram_read), W'(1));
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 64'hA5, 1'b0);
        chk("flush_level", W'(level), '0);
        chk("flush_rd_valid", W'(fifo.rd_valid), '0);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            if (fifo.rd_valid) got = 1'b1;
        end
        chk("flush_a5_seen", W'(got), W'(1));
        chk("flush_a5_data", fifo.rd_data, 64'hA5);
        drain();

        // Reset pulse in the middle of traffic.
        for (int c = 0; c < 60; c++)
            step(1'b0, 1'b1, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
        @(negedge clk);
        rst_n = 1'b0;
        fifo.wr_valid = 1'b0;
        flush = 1'b0;
        #1;
        reset_checks("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++)
            step(1'b0, 1'b1, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
        drain();

        // Random mix including occasional flushes.
        for (int c = 0; c < 2000; c++)
            step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                 {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
